instr_ctrl: RTL and testbench
=============================

# instr_ctrl

Multi-cycle fetch/decode/control sequencer for the 16-bit processor. It fetches one instruction per pass from instruction memory over a req/valid handshake, decodes it, and drives the register file's read addresses, immediate select, write address and write enable. It also produces the ALU opcode and resolves branches using register-file read port 1. It sits directly upstream of the register file and owns the program counter.

## Interface
- `PC_W`, 8: program counter / instruction address width.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request; held until accepted.
- `imem_addr`  out  PC_W  fetch address (= PC).
- `imem_valid`  in  1  instruction word present on `imem_rdata` this cycle.
- `imem_rdata`  in  16  instruction word.
- `rf_data1`  in  16  register-file read port 1 data, used for branch test.
- `reg1`, `reg2`  out  4  register-file read addresses; `reg2` carries imm4 when `isImmediate`=1.
- `isImmediate`  out  1  selects imm4 instead of register on port 2.
- `wR`  out  4  write register address.
- `writeEnable`  out  1  register-file write strobe.
- `alu_op`  out  4  ALU operation (opcode of current instruction).
- `halted`  out  1  sticky; core stopped.
- `illegal`  out  1  one-cycle pulse on reserved opcode.
- `retired`  out  16  count of completed instructions, saturating at 16'hFFFF.

## Operation
- Instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4; [7:0] = target for jumps.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (register form, reg1=rs1, reg2=rs2); 7 ADDI, 8 SUBI (reg1=rs1, reg2=imm4, isImmediate=1); 9 MOV (reg1=rs1, alu_op passes A); A BEQZ (reg1=rd; if `rf_data1`==0, PC←target else PC+1); B JMP (PC←target); C–E reserved; F HALT.
- FSM states: FETCH → DECODE → EXEC → WB → FETCH; plus HALT.
  - FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_valid`, latch IR, go DECODE.
  - DECODE: `reg1`/`reg2`/`isImmediate`/`alu_op` driven from IR (held stable through EXEC and WB).
  - EXEC: ALU-class (0–9) → WB. BEQZ/JMP: update PC, increment `retired`, → FETCH. Reserved: pulse `illegal`, PC+1, increment `retired`, → FETCH. HALT: set `halted`, → HALT.
  - WB: `writeEnable`=1, `wR`=rd, PC+1, increment `retired`, → FETCH.
  - HALT: absorbing; only `rst` exits.
- PC arithmetic modulo 2^PC_W; PC+1 at all-ones wraps to 0. Jump target zero-extended/truncated to PC_W.
- Writes to R0 allowed (no hardwired zero).
- `imem_valid` outside FETCH ignored.

## Timing
- Reset values: state FETCH, PC=RESET_PC, `imem_req`=0 while `rst` asserted and 1 in the first cycle after release, `imem_addr`=RESET_PC, `reg1`=`reg2`=`wR`=0, `isImmediate`=0, `writeEnable`=0, `alu_op`=0, `halted`=0, `illegal`=0, `retired`=0.
- Fetch latency: IR captured on the edge where `imem_req`&`imem_valid`; `imem_valid` may be high in the first FETCH cycle (zero wait) or any later cycle.
- ALU instruction: 4 cycles minimum (FETCH, DECODE, EXEC, WB); `writeEnable` high exactly one cycle, in WB.
- Branch/jump/reserved: 3 cycles minimum; never asserts `writeEnable`.
- BEQZ samples `rf_data1` in EXEC (address stable since DECODE).
- `rst` mid-fetch drops `imem_req` immediately (async); a pending `imem_valid` is discarded.
- `rst` during WB: write suppressed asynchronously.

## Structure
- Shared package `proc_pkg`: opcode enum (4-bit), FSM state enum, instruction field bit positions, PC_W default.
- One sub-module natural: `instr_field_decode` (combinational IR → reg1/reg2/isImmediate/alu_op/class flags); FSM, PC and counter stay in `instr_ctrl`.

## Test plan
- Reset release, `imem_valid` tied high, IR=16'h0123 (ADD R1,R2,R3) → cycle 4: `writeEnable`=1, `wR`=1, `reg1`=2, `reg2`=3, `isImmediate`=0; next `imem_addr`=1, `retired`=1.
- ADDI 16'h7455 with `imem_valid` delayed 3 cycles → `imem_req` held 4 cycles, `reg2`=5, `isImmediate`=1, WB 3 cycles later than zero-wait case.
- BEQZ 16'hA240 with `rf_data1`=0 → next `imem_addr`=8'h40, no `writeEnable`; same with `rf_data1`=16'h0001 → PC+1.
- PC=8'hFF executing ADD → next fetch at 8'h00; JMP 16'hB0FF → PC=8'hFF.
- Opcode 16'hC000 → `illegal` pulse one cycle, no write; HALT 16'hF000 → `halted`=1, `imem_req` stays 0 for 20 cycles; `rst` pulse → FETCH at RESET_PC, `halted`=0.
- Assert `rst` in WB cycle → `writeEnable` deasserts immediately, all outputs at reset values.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: opcodes, sequencer states,
// instruction field positions and default widths.
package proc_pkg;

    localparam int unsigned PC_W_DEF = 8;
    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned REG_AW   = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CNT_W    = 16;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_MSB = 7;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned TGT_MSB = 7;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_SHL   = 4'h5,
        OP_SHR   = 4'h6,
        OP_ADDI  = 4'h7,
        OP_SUBI  = 4'h8,
        OP_MOV   = 4'h9,
        OP_BEQZ  = 4'hA,
        OP_JMP   = 4'hB,
        OP_RSV_C = 4'hC,
        OP_RSV_D = 4'hD,
        OP_RSV_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_e;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction decode: register addresses, immediate select,
// ALU opcode and instruction class flags.
module instr_field_decode
    import proc_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [REG_AW-1:0]  reg1,
    output logic [REG_AW-1:0]  reg2,
    output logic [REG_AW-1:0]  rd,
    output logic [3:0]         alu_op,
    output logic               is_imm,
    output logic               is_alu,
    output logic               is_beqz,
    output logic               is_jmp,
    output logic               is_rsvd,
    output logic               is_halt
);

    logic [3:0] op;

    assign op = ir[OP_MSB:OP_LSB];

    always_comb begin
        reg1    = ir[RS1_MSB:RS1_LSB];
        reg2    = ir[RS2_MSB:RS2_LSB];
        rd      = ir[RD_MSB:RD_LSB];
        alu_op  = op;
        is_imm  = 1'b0;
        is_alu  = 1'b0;
        is_beqz = 1'b0;
        is_jmp  = 1'b0;
        is_rsvd = 1'b0;
        is_halt = 1'b0;
        case (opcode_e'(op))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOV: begin
                is_alu = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                is_alu = 1'b1;
                is_imm = 1'b1;
            end
            OP_BEQZ: begin
                // Branch tests the register named in the rd field on port 1
                is_beqz = 1'b1;
                reg1    = ir[RD_MSB:RD_LSB];
            end
            OP_JMP:  is_jmp  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_rsvd = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_ctrl.sv
// Fetch/decode/control sequencer: owns the PC, fetches over req/valid,
// drives register-file addressing and resolves branches.
module instr_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic [DATA_W-1:0]  rf_data1,
    output logic [REG_AW-1:0]  reg1,
    output logic [REG_AW-1:0]  reg2,
    output logic               isImmediate,
    output logic [REG_AW-1:0]  wR,
    output logic               writeEnable,
    output logic [3:0]         alu_op,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    state_e             state_q;
    logic [INSTR_W-1:0] ir_q;
    logic [PC_W-1:0]    pc_q;
    logic [REG_AW-1:0]  wr_q;
    logic               we_q;
    logic               halted_q;
    logic               illegal_q;
    logic [CNT_W-1:0]   retired_q;

    logic [REG_AW-1:0]  rd;
    logic               is_alu;
    logic               is_beqz;
    logic               is_jmp;
    logic               is_rsvd;
    logic               is_halt;

    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    target;
    logic               take_target;
    logic [CNT_W-1:0]   retired_inc;

    instr_field_decode u_decode (
        .ir      (ir_q),
        .reg1    (reg1),
        .reg2    (reg2),
        .rd      (rd),
        .alu_op  (alu_op),
        .is_imm  (isImmediate),
        .is_alu  (is_alu),
        .is_beqz (is_beqz),
        .is_jmp  (is_jmp),
        .is_rsvd (is_rsvd),
        .is_halt (is_halt)
    );

    assign pc_inc      = pc_q + PC_W'(1);
    assign target      = PC_W'(ir_q[TGT_MSB:0]);
    assign take_target = is_jmp | (is_beqz & (rf_data1 == '0));
    assign retired_inc = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);

    // Request is gated by rst so it drops the instant reset is asserted
    assign imem_req    = (state_q == S_FETCH) & ~rst;
    assign imem_addr   = pc_q;
    assign wR          = wr_q;
    assign writeEnable = we_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

    // Sequencer, PC and retirement counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            pc_q      <= RESET_PC;
            wr_q      <= '0;
            we_q      <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_q    <= imem_rdata;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_alu) begin
                        we_q    <= 1'b1;
                        wr_q    <= rd;
                        state_q <= S_WB;
                    end else if (is_halt) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        pc_q      <= take_target ? target : pc_inc;
                        retired_q <= retired_inc;
                        illegal_q <= is_rsvd;
                        state_q   <= S_FETCH;
                    end
                end
                S_WB: begin
                    we_q      <= 1'b0;
                    pc_q      <= pc_inc;
                    retired_q <= retired_inc;
                    state_q   <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_ctrl.sv
// Bench for instr_ctrl: directed vector table, random instruction stream
// against a behavioural model, and reset/halt corner sequences.
module tb_instr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [15:0] rf_data1;
    logic [3:0]  reg1, reg2, wR, alu_op;
    logic        isImmediate, writeEnable, halted, illegal;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_pc;
    logic [15:0] m_ret;

    typedef struct {
        logic [15:0] word;
        int          wt;
        logic [15:0] rf1;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic        imm;
        logic        we;
        logic [3:0]  wr;
        logic [7:0]  npc;
        logic        ill;
    } vec_t;

    vec_t tbl[11];

    instr_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .rf_data1    (rf_data1),
        .reg1        (reg1),
        .reg2        (reg2),
        .isImmediate (isImmediate),
        .wR          (wR),
        .writeEnable (writeEnable),
        .alu_op      (alu_op),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one instruction, from the ISA rules
    function automatic vec_t model(input logic [15:0] word, input int wt,
                                   input logic [15:0] rf1, input logic [7:0] pc);
        vec_t       v;
        logic [3:0] op;
        op     = word[15:12];
        v.word = word;
        v.wt   = wt;
        v.rf1  = rf1;
        v.r1   = (op == 4'hA) ? word[11:8] : word[7:4];
        v.r2   = word[3:0];
        v.imm  = (op == 4'h7) || (op == 4'h8);
        v.we   = (op <= 4'h9);
        v.wr   = word[11:8];
        v.ill  = (op >= 4'hC) && (op <= 4'hE);
        if (op == 4'hB || (op == 4'hA && rf1 == 16'h0))
            v.npc = word[7:0];
        else
            v.npc = pc + 8'd1;
        return v;
    endfunction

    // Drive one instruction through the fetch handshake and check every cycle
    task automatic run_instr(input vec_t v);
        logic [3:0] op;
        op         = v.word[15:12];
        rf_data1   = v.rf1;
        imem_rdata = v.word;
        for (int i = 0; i < v.wt; i++) begin
            imem_valid = 1'b0;
            chk("fetch_wait_req", 32'(imem_req), 32'(1'b1));
            chk("fetch_wait_addr", 32'(imem_addr), 32'(m_pc));
            @(negedge clk);
        end
        imem_valid = 1'b1;
        chk("fetch_req", 32'(imem_req), 32'(1'b1));
        chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
        chk("fetch_retired", 32'(retired), 32'(m_ret));
        @(negedge clk);
        // Anything on the fetch port is ignored until the next FETCH
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = 16'($urandom);
        chk("dec_req", 32'(imem_req), 32'(1'b0));
        chk("dec_reg1", 32'(reg1), 32'(v.r1));
        chk("dec_reg2", 32'(reg2), 32'(v.r2));
        chk("dec_imm", 32'(isImmediate), 32'(v.imm));
        chk("dec_aluop", 32'(alu_op), 32'(op));
        chk("dec_we", 32'(writeEnable), 32'(1'b0));
        chk("dec_illegal", 32'(illegal), 32'(1'b0));
        @(negedge clk);
        chk("exec_we", 32'(writeEnable), 32'(1'b0));
        chk("exec_reg1", 32'(reg1), 32'(v.r1));
        chk("exec_req", 32'(imem_req), 32'(1'b0));
        @(negedge clk);
        if (v.we) begin
            chk("wb_we", 32'(writeEnable), 32'(1'b1));
            chk("wb_wr", 32'(wR), 32'(v.wr));
            chk("wb_reg2", 32'(reg2), 32'(v.r2));
            chk("wb_req", 32'(imem_req), 32'(1'b0));
            @(negedge clk);
        end
        imem_valid = 1'b0;
        m_pc  = v.npc;
        m_ret = m_ret + 16'd1;
        chk("next_addr", 32'(imem_addr), 32'(m_pc));
        chk("next_req", 32'(imem_req), 32'(1'b1));
        chk("next_we", 32'(writeEnable), 32'(1'b0));
        chk("next_illegal", 32'(illegal), 32'(v.ill));
        chk("next_retired", 32'(retired), 32'(m_ret));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'(1'b0));
        chk({tag, "_addr"}, 32'(imem_addr), 32'(8'h00));
        chk({tag, "_reg1"}, 32'(reg1), 32'(4'h0));
        chk({tag, "_reg2"}, 32'(reg2), 32'(4'h0));
        chk({tag, "_wr"}, 32'(wR), 32'(4'h0));
        chk({tag, "_imm"}, 32'(isImmediate), 32'(1'b0));
        chk({tag, "_we"}, 32'(writeEnable), 32'(1'b0));
        chk({tag, "_aluop"}, 32'(alu_op), 32'(4'h0));
        chk({tag, "_halted"}, 32'(halted), 32'(1'b0));
        chk({tag, "_illegal"}, 32'(illegal), 32'(1'b0));
        chk({tag, "_retired"}, 32'(retired), 32'(16'h0));
    endtask

    initial begin
        //               word      wt rf1       r1    r2    imm   we    wr    npc    ill
        tbl[0]  = '{16'h0123, 0, 16'h0000, 4'h2, 4'h3, 1'b0, 1'b1, 4'h1, 8'h01, 1'b0};
        tbl[1]  = '{16'h7455, 3, 16'h0000, 4'h5, 4'h5, 1'b1, 1'b1, 4'h4, 8'h02, 1'b0};
        tbl[2]  = '{16'hA240, 0, 16'h0000, 4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 8'h40, 1'b0};
        tbl[3]  = '{16'hA240, 1, 16'h0001, 4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 8'h41, 1'b0};
        tbl[4]  = '{16'hB0FF, 0, 16'h1234, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 8'hFF, 1'b0};
        tbl[5]  = '{16'h0123, 2, 16'h0000, 4'h2, 4'h3, 1'b0, 1'b1, 4'h1, 8'h00, 1'b0};
        tbl[6]  = '{16'h9A50, 0, 16'h0000, 4'h5, 4'h0, 1'b0, 1'b1, 4'hA, 8'h01, 1'b0};
        tbl[7]  = '{16'hC000, 0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h02, 1'b1};
        tbl[8]  = '{16'hE3A7, 1, 16'h0000, 4'hA, 4'h7, 1'b0, 1'b0, 4'h0, 8'h03, 1'b1};
        tbl[9]  = '{16'h8F0F, 0, 16'h0000, 4'h0, 4'hF, 1'b1, 1'b1, 4'hF, 8'h04, 1'b0};
        tbl[10] = '{16'h0000, 0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 8'h05, 1'b0};

        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 16'h0;
        rf_data1   = 16'h0;
        m_pc       = 8'h00;
        m_ret      = 16'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        chk("release_req", 32'(imem_req), 32'(1'b1));
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 11; i++) run_instr(tbl[i]);

        // Random instruction stream against the model
        for (int n = 0; n < 150; n++) begin
            logic [15:0] w;
            logic [15:0] r;
            w[15:12] = 4'($urandom_range(0, 14));
            w[11:0]  = 12'($urandom);
            r        = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
            run_instr(model(w, $urandom_range(0, 3), r, m_pc));
        end

        // Reset during a fetch with valid pending: word must be discarded
        imem_rdata = 16'h0123;
        imem_valid = 1'b1;
        rst        = 1'b1;
        #1;
        chk("midfetch_req", 32'(imem_req), 32'(1'b0));
        @(negedge clk);
        rst        = 1'b0;
        imem_valid = 1'b0;
        m_pc       = 8'h00;
        m_ret      = 16'h0;
        #1;
        chk("midfetch_release_req", 32'(imem_req), 32'(1'b1));
        chk("midfetch_reg1", 32'(reg1), 32'(4'h0));
        @(negedge clk);
        chk("midfetch_still_fetch", 32'(imem_req), 32'(1'b1));
        run_instr(model(16'h3456, 0, 16'h0, m_pc));
        run_instr(model(16'h1789, 1, 16'h0, m_pc));

        // Reset in the write-back cycle
        imem_rdata = 16'h0123;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wbrst_pre_we", 32'(writeEnable), 32'(1'b1));
        rst = 1'b1;
        #1;
        check_reset_outputs("wbrst");
        @(negedge clk);
        rst   = 1'b0;
        m_pc  = 8'h00;
        m_ret = 16'h0;
        @(negedge clk);
        run_instr(model(16'h2111, 0, 16'h0, m_pc));

        // HALT is absorbing until reset
        imem_rdata = 16'hF000;
        imem_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("halt_req", 32'(imem_req), 32'(1'b0));
            chk("halt_flag", 32'(halted), 32'(1'b1));
            @(negedge clk);
        end
        chk("halt_addr", 32'(imem_addr), 32'(m_pc));
        chk("halt_retired", 32'(retired), 32'(m_ret));
        chk("halt_we", 32'(writeEnable), 32'(1'b0));
        imem_valid = 1'b0;
        rst        = 1'b1;
        #1;
        chk("halt_rst_flag", 32'(halted), 32'(1'b0));
        chk("halt_rst_addr", 32'(imem_addr), 32'(8'h00));
        @(negedge clk);
        rst   = 1'b0;
        m_pc  = 8'h00;
        m_ret = 16'h0;
        #1;
        chk("halt_release_req", 32'(imem_req), 32'(1'b1));
        @(negedge clk);
        run_instr(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
